// File: rtl/cache_mem_ctrl_if.sv
// Bus bundle between the cache FSM, cache_mem_ctrl and the block memory model.
// The master modport is the controller; the slave modport is the cache/memory side.
interface cache_mem_ctrl_if #(
    parameter int unsigned c_block_size = 2,
    parameter int unsigned c_line_size  = 32,
    parameter int unsigned address_size = 32
);
    localparam int unsigned BA = address_size - c_block_size - 2;
    localparam int unsigned BD = (32'd1 << c_block_size) * c_line_size;

    // cache side
    logic          c_fill_req_i;
    logic [BA-1:0] c_fill_addr_i;
    logic          c_evict_req_i;
    logic [BA-1:0] c_evict_addr_i;
    logic [BD-1:0] c_evict_data_i;
    logic          c_busy_o;
    logic [BD-1:0] c_fill_data_o;
    logic          c_fill_valid_o;
    logic          c_wb_done_o;
    logic          c_err_o;

    // memory side
    logic          mem_read_o;
    logic          mem_wr_o;
    logic [BA-1:0] mem_addr_o;
    logic [BD-1:0] mem_wr_data_o;
    logic          mem_busywait_i;
    logic [BD-1:0] mem_read_data_i;
    logic          mem_read_done_i;
    logic          mem_write_done_i;

    modport master (
        input  c_fill_req_i, c_fill_addr_i, c_evict_req_i, c_evict_addr_i, c_evict_data_i,
        output c_busy_o, c_fill_data_o, c_fill_valid_o, c_wb_done_o, c_err_o,
        output mem_read_o, mem_wr_o, mem_addr_o, mem_wr_data_o,
        input  mem_busywait_i, mem_read_data_i, mem_read_done_i, mem_write_done_i
    );

    modport slave (
        output c_fill_req_i, c_fill_addr_i, c_evict_req_i, c_evict_addr_i, c_evict_data_i,
        input  c_busy_o, c_fill_data_o, c_fill_valid_o, c_wb_done_o, c_err_o,
        input  mem_read_o, mem_wr_o, mem_addr_o, mem_wr_data_o,
        output mem_busywait_i, mem_read_data_i, mem_read_done_i, mem_write_done_i
    );
endinterface

// File: rtl/cache_mem_ctrl.sv
// Cache-side block transfer initiator: sequences write-back then fill onto the
// memory read/write/done handshake, with a per-transfer done timeout.
module cache_mem_ctrl #(
    parameter int unsigned c_block_size = 2,
    parameter int unsigned c_line_size  = 32,
    parameter int unsigned address_size = 32,
    parameter int unsigned c_timeout    = 64
) (
    input logic             m_clk_i,
    input logic             m_reset_i,
    cache_mem_ctrl_if.master bus
);
    localparam int unsigned BA = address_size - c_block_size - 2;
    localparam int unsigned BD = (32'd1 << c_block_size) * c_line_size;
    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] TO_LAST = CW'(c_timeout - 1);

    typedef enum logic [1:0] {IDLE, WB, FILL, RESP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic [BA-1:0] fill_addr_q, fill_addr_d;
    logic [BA-1:0] mem_addr_q, mem_addr_d;
    logic [BD-1:0] wr_data_q, wr_data_d;
    logic [BD-1:0] fill_data_q, fill_data_d;
    logic          err_q, err_d;
    logic          wb_done_q, wb_done_d;
    logic          busy_q, rd_q, wr_q, valid_q;
    logic          timeout_c;
    logic          busywait_unused;

    // Busywait is advisory only; the done pulses alone advance the sequence.
    assign busywait_unused = bus.mem_busywait_i;

    assign timeout_c = (cnt_q == TO_LAST);

    // Next-state and next-register values.
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        fill_addr_d = fill_addr_q;
        mem_addr_d  = mem_addr_q;
        wr_data_d   = wr_data_q;
        fill_data_d = fill_data_q;
        err_d       = err_q;
        wb_done_d   = 1'b0;
        cnt_d       = '0;

        unique case (state_q)
            IDLE: begin
                if (bus.c_evict_req_i) begin
                    state_d    = WB;
                    mem_addr_d = bus.c_evict_addr_i;
                    wr_data_d  = bus.c_evict_data_i;
                    if (bus.c_fill_req_i) begin
                        pend_d      = 1'b1;
                        fill_addr_d = bus.c_fill_addr_i;
                    end
                end else if (bus.c_fill_req_i) begin
                    state_d     = FILL;
                    fill_addr_d = bus.c_fill_addr_i;
                    mem_addr_d  = bus.c_fill_addr_i;
                end
            end
            WB: begin
                if (bus.mem_write_done_i) begin
                    wb_done_d = 1'b1;
                    if (pend_q) begin
                        state_d    = FILL;
                        pend_d     = 1'b0;
                        mem_addr_d = fill_addr_q;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (timeout_c) begin
                    err_d   = 1'b1;
                    pend_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            FILL: begin
                if (bus.mem_read_done_i) begin
                    fill_data_d = bus.mem_read_data_i;
                    state_d     = RESP;
                end else if (timeout_c) begin
                    err_d   = 1'b1;
                    pend_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Counter runs only while staying in a transfer state; any entry clears it.
        if ((state_d == state_q) && ((state_q == WB) || (state_q == FILL)))
            cnt_d = cnt_q + CW'(1);
    end

    // State and registered outputs.
    always_ff @(posedge m_clk_i or posedge m_reset_i) begin
        if (m_reset_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            fill_addr_q <= '0;
            mem_addr_q  <= '0;
            wr_data_q   <= '0;
            fill_data_q <= '0;
            err_q       <= 1'b0;
            wb_done_q   <= 1'b0;
            busy_q      <= 1'b0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            fill_addr_q <= fill_addr_d;
            mem_addr_q  <= mem_addr_d;
            wr_data_q   <= wr_data_d;
            fill_data_q <= fill_data_d;
            err_q       <= err_d;
            wb_done_q   <= wb_done_d;
            busy_q      <= (state_d != IDLE);
            rd_q        <= (state_d == FILL);
            wr_q        <= (state_d == WB);
            valid_q     <= (state_d == RESP);
        end
    end

    assign bus.c_busy_o       = busy_q;
    assign bus.c_fill_data_o  = fill_data_q;
    assign bus.c_fill_valid_o = valid_q;
    assign bus.c_wb_done_o    = wb_done_q;
    assign bus.c_err_o        = err_q;
    assign bus.mem_read_o     = rd_q;
    assign bus.mem_wr_o       = wr_q;
    assign bus.mem_addr_o     = mem_addr_q;
    assign bus.mem_wr_data_o  = wr_data_q;
endmodule
